// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-port memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// rtl/mem_arb_rr_pick.sv - round-robin choice between fetch and data requesters
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
  input  owner_t last_owner,
  output logic   valid,
  output owner_t owner
);

  always_comb begin
    valid = if_req | dm_req;
    owner = OWN_I;
    // On a tie the port that did not win last time gets the bus.
    if (if_req && dm_req) begin
      owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (dm_req) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-at-a-time sharing of the memory bus between fetch and data ports
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_we,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  busy
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CTR_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CTR_MAX  = CW'(TIMEOUT);

  state_t                state;
  owner_t                owner;
  owner_t                last_owner;
  logic [CW-1:0]         ctr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic   pick_valid;
  owner_t pick_owner;
  logic   handshake;
  logic   resp_hit;
  logic   timeout_hit;
  logic   done;

  mem_arb_rr_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .owner      (pick_owner)
  );

  always_comb begin
    handshake   = (state == ISSUE) && mem_req_ready;
    resp_hit    = (state == WAIT_RESP) && mem_resp_valid;
    timeout_hit = (state == WAIT_RESP) && !mem_resp_valid && (ctr == CTR_LAST);
    done        = resp_hit || timeout_hit;
  end

  // Pulses are masked while reset is held so an aborted transaction never completes.
  always_comb begin
    if_gnt        = handshake && (owner == OWN_I) && !reset;
    dm_gnt        = handshake && (owner == OWN_D) && !reset;
    if_rvalid     = done && (owner == OWN_I) && !reset;
    dm_rvalid     = done && (owner == OWN_D) && !reset;
    resp_err      = timeout_hit && !reset;
    rdata         = ((state == WAIT_RESP) && !timeout_hit) ? mem_resp_data : '0;
    mem_req_valid = (state == ISSUE);
    mem_req_addr  = req_addr;
    mem_req_we    = req_we;
    mem_req_wdata = req_wdata;
    busy          = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      ctr        <= '0;
      req_addr   <= '0;
      req_we     <= 1'b0;
      req_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick_owner;
            if (pick_owner == OWN_D) begin
              req_addr  <= dm_addr;
              req_we    <= dm_we;
              req_wdata <= dm_wdata;
            end else begin
              req_addr  <= if_addr;
              req_we    <= 1'b0;
              req_wdata <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            last_owner <= owner;
            ctr        <= '0;
            state      <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (done) begin
            state <= IDLE;
          end else if (ctr != CTR_MAX) begin
            ctr <= ctr + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
